tone_sequencer: RTL and testbench
=================================

TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL expose parameter CHANNELS, default 2, meaning number of independent tone channels (1..15).
REQ-002 SHALL expose parameter DIV_WIDTH, default 16, meaning width of the half-period divider per channel.
REQ-003 SHALL expose parameter DUR_WIDTH, default 16, meaning width of the per-channel duration counter.
REQ-004 SHALL expose parameter PRESCALE_RESET, default 12000, meaning reset value of the duration tick prescaler (1 ms at 12 MHz).
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 address  input  6  register select.
REQ-008 data_in  input  16  write data.
REQ-009 write_enable  input  1  high = write cycle, low = read cycle.
REQ-010 data_out  output  16  registered read data.
REQ-011 speaker_p  output  CHANNELS  per-channel tone output, positive phase.
REQ-012 speaker_m  output  CHANNELS  per-channel tone output, negative phase.
REQ-013 irq  output  1  level interrupt: OR over channels of (done & irq_en).

Function
REQ-014 Register map SHALL be: channel c at 4c+0 DIVIDER, 4c+1 DURATION, 4c+2 CTRL, 4c+3 REMAIN (read-only); 0x3C PRESCALE; 0x3D DONE; unmapped addresses read 0, ignore writes.
REQ-015 CTRL bits SHALL be: bit0 start (write-only strobe), bit1 stop (write-only strobe), bit2 loop, bit3 irq_en, bit4 busy (read-only).
REQ-016 Reads SHALL return data one clk after an address presented with write_enable low; data_out holds its value during write cycles.
REQ-017 Each channel SHALL run an FSM with states IDLE and PLAY; busy = (state == PLAY).
REQ-018 Writing CTRL with start=1 SHALL enter PLAY next cycle, clearing that channel's phase counter and toggle and loading REMAIN from DURATION, unless DIVIDER == 0, in which case the channel stays IDLE.
REQ-019 In PLAY, phase counter SHALL increment each clk; on reaching DIVIDER it resets to 0 and toggle inverts; speaker_p <= toggle, speaker_m <= ~toggle.
REQ-020 In IDLE, speaker_p and speaker_m for that channel SHALL both be 0.
REQ-021 A shared prescaler SHALL count 0..PRESCALE-1 and emit a one-cycle tick on wrap; PRESCALE == 0 SHALL be treated as 1 (tick every clk).
REQ-022 In PLAY with DURATION != 0, each tick SHALL decrement REMAIN; tick with REMAIN == 1 SHALL end the note.
REQ-023 Note end SHALL set the channel's DONE bit; loop=0 returns to IDLE, loop=1 reloads REMAIN from DURATION and stays in PLAY without phase discontinuity.
REQ-024 DURATION == 0 SHALL mean continuous play: REMAIN not decremented, DONE never set.
REQ-025 Writing DIVIDER while in PLAY SHALL take effect at the next phase wrap; if phase counter already exceeds the new value it SHALL wrap on the next clk.
REQ-026 stop strobe SHALL force IDLE next cycle without setting DONE; start and stop written together SHALL act as stop.
REQ-027 Writing DONE SHALL clear each bit written 1 (write-1-to-clear); a hardware set coinciding with a clear of the same bit SHALL leave the bit set.
REQ-028 Counter arithmetic SHALL be unsigned, DIV_WIDTH/DUR_WIDTH bits, narrower register fields zero-extended on read, upper data_in bits ignored on write.
REQ-029 Start written while already in PLAY SHALL restart the note (same as REQ-018).

Reset
REQ-030 While reset is low, all channels SHALL be IDLE; DIVIDER, DURATION, REMAIN, CTRL bits, DONE, phase counters, toggles = 0; PRESCALE = PRESCALE_RESET; prescaler count = 0.
REQ-031 While reset is low, data_out, speaker_p, speaker_m and irq SHALL be 0, asserting asynchronously mid-note.

Verification
REQ-032 PRESCALE=1, ch0 DIVIDER=3, DURATION=0, start -> speaker_p0 toggles every 4 clk, speaker_m0 = ~speaker_p0, busy reads 1 indefinitely.
REQ-033 PRESCALE=1, ch1 DIVIDER=2, DURATION=5, irq_en=1, start -> busy for 5 ticks, then IDLE, DONE=0x0002, irq=1; write DONE=0x0002 -> irq=0.
REQ-034 Same as 033 with loop=1 -> DONE set every 5 ticks, busy stays 1, tone continuous; stop -> outputs 0 next cycle, DONE unchanged.
REQ-035 DIVIDER=0, start -> busy stays 0, outputs 0; unmapped address 0x20 read -> 0.
REQ-036 Reset low mid-note with DONE=0x0001 -> all outputs 0 immediately; after release PRESCALE reads PRESCALE_RESET, DONE reads 0.
REQ-037 DONE hardware set and software clear same cycle -> bit remains 1.

Source files
------------

// File: rtl/tone_sequencer.sv
// Multi-channel square-wave tone generator with a register interface, shared
// duration prescaler, per-channel note timing, looping and done interrupts.

module tone_channel #(
    parameter int DIV_WIDTH = 16,
    parameter int DUR_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        div_we,
    input  logic        dur_we,
    input  logic        ctrl_we,
    input  logic        done_clr,
    input  logic [15:0] wdata,
    output logic [15:0] rd_div,
    output logic [15:0] rd_dur,
    output logic [15:0] rd_ctrl,
    output logic [15:0] rd_remain,
    output logic        done,
    output logic        irq_en,
    output logic        speaker_p,
    output logic        speaker_m
);
    typedef enum logic {IDLE, PLAY} state_t;

    localparam logic [DUR_WIDTH-1:0] REM_ONE = DUR_WIDTH'(1);

    state_t               state;
    logic [DIV_WIDTH-1:0] divider;
    logic [DIV_WIDTH-1:0] phase;
    logic [DUR_WIDTH-1:0] duration;
    logic [DUR_WIDTH-1:0] remain;
    logic                 toggle;
    logic                 loop;
    logic                 start;
    logic                 stop;
    logic                 note_end;

    assign start = ctrl_we & wdata[0];
    assign stop  = ctrl_we & wdata[1];

    // A start or stop in the same cycle overrides a natural note end.
    always_comb begin
        note_end = 1'b0;
        if (state == PLAY && tick && duration != '0 && remain == REM_ONE && !start && !stop)
            note_end = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            divider  <= '0;
            duration <= '0;
            remain   <= '0;
            phase    <= '0;
            toggle   <= 1'b0;
            loop     <= 1'b0;
            irq_en   <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (div_we)
                divider <= DIV_WIDTH'(wdata);
            if (dur_we)
                duration <= DUR_WIDTH'(wdata);
            if (ctrl_we) begin
                loop   <= wdata[2];
                irq_en <= wdata[3];
            end
            // Hardware set has priority over a write-1-to-clear.
            done <= (done & ~done_clr) | note_end;

            if (stop) begin
                state <= IDLE;
            end else if (start) begin
                if (divider != '0) begin
                    state  <= PLAY;
                    phase  <= '0;
                    toggle <= 1'b0;
                    remain <= duration;
                end else begin
                    state <= IDLE;
                end
            end else if (state == PLAY) begin
                // >= lets a shrunken divider wrap on the very next clock.
                if (phase >= divider) begin
                    phase  <= '0;
                    toggle <= ~toggle;
                end else begin
                    phase <= phase + DIV_WIDTH'(1);
                end
                if (tick && duration != '0) begin
                    if (remain == REM_ONE) begin
                        if (loop)
                            remain <= duration;
                        else
                            state <= IDLE;
                    end else begin
                        remain <= remain - REM_ONE;
                    end
                end
            end
        end
    end

    assign speaker_p = (state == PLAY) &  toggle;
    assign speaker_m = (state == PLAY) & ~toggle;

    assign rd_div    = 16'(divider);
    assign rd_dur    = 16'(duration);
    assign rd_remain = 16'(remain);
    assign rd_ctrl   = {11'd0, state == PLAY, irq_en, loop, 2'b00};
endmodule

module tone_sequencer #(
    parameter int CHANNELS       = 2,
    parameter int DIV_WIDTH      = 16,
    parameter int DUR_WIDTH      = 16,
    parameter int PRESCALE_RESET = 12000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          address,
    input  logic [15:0]         data_in,
    input  logic                write_enable,
    output logic [15:0]         data_out,
    output logic [CHANNELS-1:0] speaker_p,
    output logic [CHANNELS-1:0] speaker_m,
    output logic                irq
);
    localparam logic [5:0] ADDR_PRESCALE = 6'h3C;
    localparam logic [5:0] ADDR_DONE     = 6'h3D;

    logic [15:0]                    prescale;
    logic [15:0]                    presc_cnt;
    logic [15:0]                    presc_lim;
    logic                           tick;
    logic [CHANNELS-1:0][3:0][15:0] ch_rd;
    logic [CHANNELS-1:0]            done_vec;
    logic [CHANNELS-1:0]            irq_en_vec;
    logic [15:0]                    rdata;

    // Zero prescale behaves as one so durations still advance every clock.
    assign presc_lim = (prescale == 16'd0) ? 16'd1 : prescale;
    assign tick      = presc_cnt >= presc_lim - 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale  <= 16'(PRESCALE_RESET);
            presc_cnt <= '0;
        end else begin
            if (write_enable && address == ADDR_PRESCALE)
                prescale <= data_in;
            presc_cnt <= tick ? 16'd0 : presc_cnt + 16'd1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic sel;
        assign sel = write_enable && address[5:2] == 4'(c);

        tone_channel #(
            .DIV_WIDTH (DIV_WIDTH),
            .DUR_WIDTH (DUR_WIDTH)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .div_we    (sel && address[1:0] == 2'd0),
            .dur_we    (sel && address[1:0] == 2'd1),
            .ctrl_we   (sel && address[1:0] == 2'd2),
            .done_clr  (write_enable && address == ADDR_DONE && data_in[c]),
            .wdata     (data_in),
            .rd_div    (ch_rd[c][0]),
            .rd_dur    (ch_rd[c][1]),
            .rd_ctrl   (ch_rd[c][2]),
            .rd_remain (ch_rd[c][3]),
            .done      (done_vec[c]),
            .irq_en    (irq_en_vec[c]),
            .speaker_p (speaker_p[c]),
            .speaker_m (speaker_m[c])
        );
    end

    always_comb begin
        rdata = 16'd0;
        if (address == ADDR_PRESCALE) begin
            rdata = prescale;
        end else if (address == ADDR_DONE) begin
            rdata = 16'(done_vec);
        end else begin
            for (int c = 0; c < CHANNELS; c++)
                if (address[5:2] == 4'(c))
                    rdata = ch_rd[c][address[1:0]];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            data_out <= '0;
        else if (!write_enable)
            data_out <= rdata;
    end

    assign irq = |(done_vec & irq_en_vec);
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: register reads go through an expected-value
// queue; tone, busy and irq behaviour are checked cycle by cycle.

module tb_tone_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  address;
    logic [15:0] data_in;
    logic        write_enable;
    logic [15:0] data_out;
    logic [1:0]  speaker_p;
    logic [1:0]  speaker_m;
    logic        irq;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    tone_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .data_in      (data_in),
        .write_enable (write_enable),
        .data_out     (data_out),
        .speaker_p    (speaker_p),
        .speaker_m    (speaker_m),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        address = a; data_in = d; write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [15:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        address = a; write_enable = 1'b0;
        @(negedge clk);
        check(tag_q.pop_front(), data_out, exp_q.pop_front());
    endtask

    initial begin
        reset = 1'b0; address = '0; data_in = '0; write_enable = 1'b0;
        #1;
        check("rst_data_out", data_out, 16'h0);
        check("rst_spk_p", 16'(speaker_p), 16'h0);
        check("rst_spk_m", 16'(speaker_m), 16'h0);
        check("rst_irq", 16'(irq), 16'h0);
        #20;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        rd(6'h3C, 16'd12000, "prescale_rst");
        rd(6'h3D, 16'h0000, "done_rst");
        rd(6'h00, 16'h0000, "div0_rst");
        rd(6'h3C, 16'd12000, "prescale_again");
        wr(6'h3C, 16'd1);
        check("data_out_hold_on_write", data_out, 16'd12000);

        // Continuous tone on ch0, divider 3
        wr(6'h00, 16'd3);
        wr(6'h01, 16'd0);
        wr(6'h02, 16'h0001);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("ch0_p_k%0d", k), 16'(speaker_p[0]), 16'((k / 4) % 2));
            check($sformatf("ch0_m_k%0d", k), 16'(speaker_m[0]), 16'(1 - (k / 4) % 2));
            @(negedge clk);
        end
        rd(6'h02, 16'h0010, "ch0_busy");
        rd(6'h03, 16'h0000, "ch0_remain_cont");
        wr(6'h02, 16'h0002);
        check("ch0_stop_p", 16'(speaker_p[0]), 16'h0);
        check("ch0_stop_m", 16'(speaker_m[0]), 16'h0);

        // One-shot note on ch1, divider 2, duration 5, irq enabled
        wr(6'h04, 16'd2);
        wr(6'h05, 16'd5);
        wr(6'h06, 16'h0009);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("ch1_busy_k%0d", k), 16'(speaker_p[1] | speaker_m[1]), 16'(k < 5));
            if (k < 5)
                check($sformatf("ch1_p_k%0d", k), 16'(speaker_p[1]), 16'((k / 3) % 2));
            check($sformatf("ch1_irq_k%0d", k), 16'(irq), 16'(k == 5));
            @(negedge clk);
        end
        rd(6'h3D, 16'h0002, "done_after_note");
        rd(6'h06, 16'h0008, "ch1_ctrl_idle");
        wr(6'h3D, 16'h0002);
        check("irq_after_clear", 16'(irq), 16'h0);
        rd(6'h3D, 16'h0000, "done_cleared");

        // Looping note: done every 5 ticks, tone uninterrupted
        wr(6'h06, 16'h000D);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("loop_busy_k%0d", k), 16'(speaker_p[1] | speaker_m[1]), 16'h1);
            check($sformatf("loop_p_k%0d", k), 16'(speaker_p[1]), 16'((k / 3) % 2));
            check($sformatf("loop_irq_k%0d", k), 16'(irq), 16'(k >= 5));
            @(negedge clk);
        end
        wr(6'h06, 16'h000B);
        check("loop_stop_p", 16'(speaker_p[1]), 16'h0);
        check("loop_stop_m", 16'(speaker_m[1]), 16'h0);
        check("loop_stop_irq", 16'(irq), 16'h1);
        rd(6'h3D, 16'h0002, "done_after_stop");
        wr(6'h3D, 16'h0002);
        rd(6'h3D, 16'h0000, "done_cleared2");

        // Hardware set and software clear in the same cycle; prescale 0 acts as 1
        wr(6'h3C, 16'd0);
        wr(6'h05, 16'd3);
        wr(6'h06, 16'h0009);
        @(negedge clk);
        @(negedge clk);
        wr(6'h3D, 16'h0002);
        rd(6'h3D, 16'h0002, "done_set_wins");
        check("irq_set_wins", 16'(irq), 16'h1);
        rd(6'h3C, 16'h0000, "prescale_zero");

        // Divider 0 never plays; unmapped address reads 0
        wr(6'h00, 16'd0);
        wr(6'h02, 16'h0001);
        check("div0_p", 16'(speaker_p[0]), 16'h0);
        check("div0_m", 16'(speaker_m[0]), 16'h0);
        rd(6'h02, 16'h0000, "div0_not_busy");
        wr(6'h20, 16'hFFFF);
        rd(6'h20, 16'h0000, "unmapped_read");

        // Reset mid-note with ch0 done set
        wr(6'h3D, 16'h0002);
        wr(6'h00, 16'd3);
        wr(6'h01, 16'd2);
        wr(6'h02, 16'h000D);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_irq", 16'(irq), 16'h1);
        rd(6'h3D, 16'h0001, "pre_rst_done");
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_data_out", data_out, 16'h0);
        check("async_rst_spk_p", 16'(speaker_p), 16'h0);
        check("async_rst_spk_m", 16'(speaker_m), 16'h0);
        check("async_rst_irq", 16'(irq), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        rd(6'h3C, 16'd12000, "prescale_after_rst");
        rd(6'h3D, 16'h0000, "done_after_rst");
        rd(6'h02, 16'h0000, "ctrl0_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
